ef_apb_initiator: RTL and testbench
===================================

EF_APB_INITIATOR -- requirements
Module: ef_apb_initiator

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 16, maximum ACCESS-phase wait cycles before abort (legal 1..255).
REQ-002 SHALL have port: PCLK  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: PRESETn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cmd_valid  in  1  command request.
REQ-005 SHALL have port: cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-006 SHALL have port: cmd_write  in  1  1=write, 0=read.
REQ-007 SHALL have port: cmd_addr  in  32  target address.
REQ-008 SHALL have port: cmd_wdata  in  32  write data.
REQ-009 SHALL have port: rsp_valid  out  1  response available.
REQ-010 SHALL have port: rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-011 SHALL have port: rsp_rdata  out  32  read data (0 for writes and timeouts).
REQ-012 SHALL have port: rsp_timeout  out  1  transfer aborted by timeout.
REQ-013 SHALL have ports: PADDR out 32, PWRITE out 1, PSEL out 1, PENABLE out 1, PWDATA out 32, PRDATA in 32, PREADY in 1 -- APB requester side.
REQ-014 SHALL have port: busy  out  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-016 cmd_ready SHALL be 1 only in IDLE; cmd_* sampled only on cmd_valid&cmd_ready, captured into internal registers, next state SETUP.
REQ-017 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = captured values; next state ACCESS unconditionally after one cycle.
REQ-018 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable; remain until PREADY=1.
REQ-019 On PREADY=1 in ACCESS: register PRDATA into rsp_rdata if read (0 if write), rsp_timeout=0, next state RESP; PSEL/PENABLE low next cycle.
REQ-020 RESP: rsp_valid=1, rsp_rdata/rsp_timeout stable until rsp_valid&rsp_ready; then IDLE.
REQ-021 Latency: command accepted cycle N -> PSEL at N+1, PENABLE at N+2, rsp_valid at N+3 when PREADY=1 at N+2; back-to-back with rsp_ready=1 = 4 cycles per transfer.
REQ-022 Outside SETUP/ACCESS PSEL=0 and PENABLE=0; PADDR/PWRITE/PWDATA retain last driven values.
REQ-023 cmd_* changes while cmd_ready=0 SHALL be ignored; only one transfer outstanding.
REQ-024 Any PREADY/PRDATA value outside ACCESS SHALL be ignored.

Reset
REQ-025 On PRESETn low, immediately: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, busy=0, cmd_ready=0 while asserted, timeout counter=0.
REQ-026 Reset mid-transfer SHALL discard the command with no response; cmd_ready=1 first cycle after PRESETn rises.

Configuration
REQ-027 Macro EF_APB_INITIATOR_TIMEOUT_EN defined: 8-bit counter clears on ACCESS entry, increments each ACCESS cycle with PREADY=0; when it reaches TIMEOUT_CYCLES without PREADY, abort -> RESP with rsp_timeout=1, rsp_rdata=0, PSEL/PENABLE low next cycle; PREADY arriving in the same cycle as expiry wins (normal completion).
REQ-028 Macro undefined: no counter logic, ACCESS waits indefinitely, rsp_timeout constant 0, TIMEOUT_CYCLES unused.

Verification
REQ-029 Write addr 0x0000_0004 data 0xA5 with PREADY tied 1 -> PSEL at N+1, PENABLE at N+2, PWRITE=1 PWDATA=0xA5, rsp_valid at N+3, rsp_rdata=0.
REQ-030 Read addr 0x0000_0008, PREADY low 3 ACCESS cycles, PRDATA=0xDEADBEEF when PREADY=1 -> PADDR/PSEL/PENABLE stable 4 ACCESS cycles, rsp_rdata=0xDEADBEEF.
REQ-031 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, new cmd_valid ignored until handshake.
REQ-032 PRESETn pulsed low during ACCESS -> PSEL/PENABLE 0 asynchronously, no rsp_valid, cmd_ready=1 first cycle after release.
REQ-033 With EF_APB_INITIATOR_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0 -> rsp_timeout=1, rsp_rdata=0 after 4 ACCESS cycles; without macro, still waiting after 100 cycles.

Source files
------------

// File: rtl/ef_apb_initiator.sv
// rtl/ef_apb_initiator.sv - single-outstanding APB requester with a command/response handshake.
// Optional ACCESS-phase abort counter enabled by EF_APB_INITIATOR_TIMEOUT_EN.
module ef_apb_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        pwrite_q, pwrite_d;
  logic        expire;

`ifdef EF_APB_INITIATOR_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  // expire fires on the wait cycle that brings the count to the limit.
  always_comb begin
    cnt_d     = cnt_q;
    expire    = 1'b0;
    timeout_d = timeout_q;
    if (state_q == SETUP) begin
      cnt_d = 8'd0;
    end else if (state_q == ACCESS) begin
      if (!PREADY) begin
        cnt_d  = cnt_q + 8'd1;
        expire = (cnt_d == TO_LIMIT);
      end
      timeout_d = !PREADY && expire;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign rsp_timeout = timeout_q;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES != 0);
  assign expire               = 1'b0;
  assign rsp_timeout          = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          state_d  = SETUP;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          rdata_d = pwrite_q ? 32'd0 : PRDATA;
          state_d = RESP;
        end else if (expire) begin
          rdata_d = 32'd0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      paddr_q  <= 32'd0;
      pwdata_q <= 32'd0;
      pwrite_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
    end
  end

  // Gated by PRESETn so no command is accepted while reset is held.
  assign cmd_ready = (state_q == IDLE) && PRESETn;
  assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE   = (state_q == ACCESS);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ef_apb_initiator.sv
// tb/tb_ef_apb_initiator.sv - self-checking bench for ef_apb_initiator.
module tb_ef_apb_initiator;

  localparam int TO = 4;
`ifdef EF_APB_INITIATOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        PCLK, PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, busy;

  int total = 0;
  int bad   = 0;

  ef_apb_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .busy(busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] prd;
    int          waitc;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_to;
    int          exp_acc;
  } vec_t;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference outcome of a transfer from the protocol rules alone.
  function automatic void model(input logic w, input logic [31:0] prd, input int waitc,
                                output logic [31:0] r, output logic to, output int acc);
    if (TO_EN && waitc >= TO) begin
      r = 32'd0; to = 1'b1; acc = TO;
    end else begin
      r = w ? 32'd0 : prd; to = 1'b0; acc = waitc + 1;
    end
  endfunction

  task automatic run_txn(input vec_t v);
    cmd_valid = 1'b1; cmd_write = v.w; cmd_addr = v.a; cmd_wdata = v.d; rsp_ready = 1'b0;
    check("accept_cmd_ready", cmd_ready, 1);
    tick();
    // Disturb command inputs and PREADY/PRDATA while they must be ignored.
    cmd_addr = ~v.a; cmd_wdata = ~v.d; cmd_write = ~v.w;
    PREADY = 1'b1; PRDATA = $urandom;
    check("setup_psel", PSEL, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_paddr", PADDR, v.a);
    check("setup_pwrite", PWRITE, v.w);
    check("setup_pwdata", PWDATA, v.d);
    check("setup_cmd_ready", cmd_ready, 0);
    tick();
    for (int i = 0; i < v.exp_acc; i++) begin
      PREADY = (i >= v.waitc);
      PRDATA = (i >= v.waitc) ? v.prd : $urandom;
      check("access_psel", PSEL, 1);
      check("access_penable", PENABLE, 1);
      check("access_paddr", PADDR, v.a);
      check("access_pwdata", PWDATA, v.d);
      check("access_rsp_valid", rsp_valid, 0);
      tick();
    end
    PREADY = 1'b1; PRDATA = $urandom;
    check("resp_valid", rsp_valid, 1);
    check("resp_rdata", rsp_rdata, v.exp_rdata);
    check("resp_timeout", rsp_timeout, v.exp_to);
    check("resp_psel", PSEL, 0);
    check("resp_penable", PENABLE, 0);
    check("resp_paddr_kept", PADDR, v.a);
    for (int i = 0; i < v.hold; i++) begin
      tick();
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, v.exp_rdata);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_psel", PSEL, 0);
    end
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    tick();
    rsp_ready = 1'b0; PREADY = 1'b0;
    check("done_valid", rsp_valid, 0);
    check("done_cmd_ready", cmd_ready, 1);
    check("done_busy", busy, 0);
  endtask

  vec_t vt[4];
  vec_t rv;

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1234;
    cmd_wdata = 32'h55; rsp_ready = 1'b0; PRDATA = 32'hFFFF_FFFF; PREADY = 1'b1;
    #1;
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    tick(); tick();
    check("rst_held_busy", busy, 0);
    cmd_valid = 1'b0; PREADY = 1'b0;
    PRESETn = 1'b1;
    #1;
    check("rst_release_cmd_ready", cmd_ready, 1);
    tick();

    vt[0] = '{1'b1, 32'h0000_0004, 32'h0000_00A5, 32'h1234_5678, 0, 0, 32'h0, 1'b0, 1};
    vt[1] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 32'hDEAD_BEEF, 3, 0, 32'hDEAD_BEEF, 1'b0, 4};
    vt[2] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 32'hCAFE_F00D, 0, 5, 32'hCAFE_F00D, 1'b0, 1};
    vt[3] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_1234, 32'h8765_4321, 1, 1, 32'h0, 1'b0, 2};
    for (int k = 0; k < 4; k++) run_txn(vt[k]);

    for (int k = 0; k < 24; k++) begin
      rv.w = 1'(($urandom % 2));
      rv.a = $urandom; rv.d = $urandom; rv.prd = $urandom;
      rv.waitc = $urandom_range(0, 6);
      rv.hold = $urandom_range(0, 3);
      model(rv.w, rv.prd, rv.waitc, rv.exp_rdata, rv.exp_to, rv.exp_acc);
      run_txn(rv);
    end

    // Stuck PREADY.
`ifdef EF_APB_INITIATOR_TIMEOUT_EN
    rv = '{1'b0, 32'h0000_0020, 32'h0, 32'h1111_2222, 1000, 2, 32'h0, 1'b1, TO};
    run_txn(rv);
`else
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; cmd_wdata = 32'h0; PREADY = 1'b0;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 101; i++) tick();
    check("stuck_penable", PENABLE, 1);
    check("stuck_rsp_valid", rsp_valid, 0);
    check("stuck_timeout", rsp_timeout, 0);
    PRESETn = 1'b0; #1; PRESETn = 1'b1;
    tick();
`endif

    // Reset pulse in the middle of ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h99; PREADY = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("pre_rst_penable", PENABLE, 1);
    PRESETn = 1'b0;
    #1;
    check("midrst_psel", PSEL, 0);
    check("midrst_penable", PENABLE, 0);
    check("midrst_paddr", PADDR, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    tick();
    PREADY = 1'b1;
    PRESETn = 1'b1;
    #1;
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_rsp_valid", rsp_valid, 0);
    tick();
    check("post_rst_idle_rsp", rsp_valid, 0);
    check("post_rst_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
